// File: rtl/frame_shift_engine.sv
// N-bit parallel-load shift register with serial in/out and a frame bit counter (busy/done).
// Latency: q updates on the load/shift edge; sout is combinational from q. No backpressure: every shift_en tick is taken.
// Optional even-parity check of the completed frame via par_err when FRAME_SHIFT_PARITY_EN is defined.
module frame_shift_engine #(
    parameter int          N         = 11,
    parameter bit          LSB_FIRST = 1'b0,
    parameter logic [N-1:0] IDLE_VAL = {N{1'b1}},
    localparam int         CW        = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          arm,
    input  logic          shift_en,
    input  logic          sin,
    input  logic [N-1:0]  d,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
`ifdef FRAME_SHIFT_PARITY_EN
    ,
    output logic          par_err
`endif
);

    logic [N-1:0]  q_q, q_d, shifted;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          last_bit;

    always_comb begin
        if (LSB_FIRST) shifted = {sin, q_q[N-1:1]};
        else           shifted = {q_q[N-2:0], sin};
    end

    // The Nth accepted shift of an active frame closes it.
    assign last_bit = busy_q && (count_q == CW'(N - 1));

    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (load) begin
            q_d     = d;
            count_d = '0;
            busy_d  = 1'b1;
        end else if (arm) begin
            count_d = '0;
            busy_d  = 1'b1;
        end else if (shift_en) begin
            q_d = shifted;
            if (last_bit) begin
                count_d = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else if (busy_q) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q     <= IDLE_VAL;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q     = q_q;
    assign sout  = LSB_FIRST ? q_q[0] : q_q[N-1];
    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

`ifdef FRAME_SHIFT_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (load || arm)                               par_d = 1'b0;
        else if (shift_en && last_bit)                 par_d = ^shifted;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    assign par_err = par_q;
`endif

endmodule

// File: tb/tb_frame_shift_engine.sv
// Scoreboarded bench: one MSB-first and one LSB-first instance share the stimulus; a frame-level model predicts every cycle.
module tb_frame_shift_engine;

    localparam int N  = 11;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load = 1'b0, arm = 1'b0, shift_en = 1'b0, sin = 1'b0;
    logic [N-1:0]  d = '0;
    logic [N-1:0]  q0, q1;
    logic          sout0, sout1, busy0, busy1, done0, done1;
    logic [CW-1:0] count0, count1;
`ifdef FRAME_SHIFT_PARITY_EN
    logic          par0, par1;
`endif

    always #5 clk = ~clk;

    frame_shift_engine #(.N(N), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset(reset), .load(load), .arm(arm), .shift_en(shift_en),
        .sin(sin), .d(d), .q(q0), .sout(sout0), .busy(busy0), .done(done0), .count(count0)
`ifdef FRAME_SHIFT_PARITY_EN
        , .par_err(par0)
`endif
    );

    frame_shift_engine #(.N(N), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .load(load), .arm(arm), .shift_en(shift_en),
        .sin(sin), .d(d), .q(q1), .sout(sout1), .busy(busy1), .done(done1), .count(count1)
`ifdef FRAME_SHIFT_PARITY_EN
        , .par_err(par1)
`endif
    );

    typedef struct {
        logic [N-1:0] q0, q1;
        int           cnt;
        bit           busy, done, par0, par1;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int checks = 0;
    int fails  = 0;

    // Reference model: frame state in plain arithmetic terms.
    logic [N-1:0] mq0, mq1;
    int           mcnt;
    bit           mbusy, mdone, mpar0, mpar1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_exp();
        exp_t x;
        x.q0 = mq0; x.q1 = mq1; x.cnt = mcnt; x.busy = mbusy; x.done = mdone;
        x.par0 = mpar0; x.par1 = mpar1;
        sbq.push_back(x);
    endfunction

    function automatic void model(input bit ld, input bit ar, input bit sh, input bit s,
                                  input logic [N-1:0] dd);
        mdone = 1'b0;
        if (ld) begin
            mq0 = dd; mq1 = dd; mcnt = 0; mbusy = 1'b1; mpar0 = 1'b0; mpar1 = 1'b0;
        end else if (ar) begin
            mcnt = 0; mbusy = 1'b1; mpar0 = 1'b0; mpar1 = 1'b0;
        end else if (sh) begin
            mq0 = (mq0 << 1) | N'(s);
            mq1 = (mq1 >> 1) | (N'(s) << (N - 1));
            if (mbusy) begin
                mcnt++;
                if (mcnt == N) begin
                    mcnt  = 0;
                    mbusy = 1'b0;
                    mdone = 1'b1;
                    mpar0 = ($countones(mq0) % 2) == 1;
                    mpar1 = ($countones(mq1) % 2) == 1;
                end
            end
        end
    endfunction

    task automatic step(input bit ld, input bit ar, input bit sh, input bit s, input logic [N-1:0] dd);
        load = ld; arm = ar; shift_en = sh; sin = s; d = dd;
        model(ld, ar, sh, s, dd);
        push_exp();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Asserts reset between edges and checks the outputs before any clock edge.
    task automatic do_reset();
        load = 1'b0; arm = 1'b0; shift_en = 1'b0; sin = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_q0", q0, 11'h7FF);
        chk("rst_q1", q1, 11'h7FF);
        chk("rst_sout0", sout0, 1);
        chk("rst_sout1", sout1, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_count", count0, 0);
        chk("rst_done", done0, 0);
        mq0 = '1; mq1 = '1; mcnt = 0; mbusy = 1'b0; mdone = 1'b0; mpar0 = 1'b0; mpar1 = 1'b0;
        push_exp();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_frame(input logic [N-1:0] bits);
        logic [N-1:0] b;
        b = bits;
        step(1'b1, 1'b0, 1'b0, 1'b0, N'($urandom));
        for (int i = N - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, b[i], '0);
        chk("frame_done", done0, 1);
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_q_msb", q0, e.q0);
            chk("sb_q_lsb", q1, e.q1);
            chk("sb_sout_msb", sout0, (e.q0 >> (N - 1)) & 1);
            chk("sb_sout_lsb", sout1, e.q1 & 1);
            chk("sb_count_msb", count0, e.cnt);
            chk("sb_count_lsb", count1, e.cnt);
            chk("sb_busy", {busy1, busy0}, {e.busy, e.busy});
            chk("sb_done", {done1, done0}, {e.done, e.done});
`ifdef FRAME_SHIFT_PARITY_EN
            chk("sb_par_msb", par0, e.par0);
            chk("sb_par_lsb", par1, e.par1);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] txv;
        logic [N-1:0] rxv;
        int r;
        txv = 11'b0_1010_0101_1_1;
        rxv = 11'b1_0100_0101_10;

        @(negedge clk);
        do_reset();

        // TX, MSB-first: sout walks d from MSB, ones refill behind it.
        step(1'b1, 1'b0, 1'b0, 1'b0, txv);
        for (int i = 0; i < N; i++) begin
            chk("tx_sout", sout0, txv[N-1-i]);
            step(1'b0, 1'b0, 1'b1, 1'b1, '0);
        end
        chk("tx_done", done0, 1);
        chk("tx_busy", busy0, 0);
        chk("tx_q", q0, 11'h7FF);
        idle();
        chk("tx_done_clear", done0, 0);

        // RX, LSB-first with gaps: bits arrive in order 0,1,1,0,1,0,0,0,1,0,1.
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                idle(); idle(); idle();
            end
            chk("rx_count", count1, i);
            step(1'b0, 1'b0, 1'b1, rxv[i], '0);
        end
        chk("rx_done", done1, 1);
        chk("rx_count_wrap", count1, 0);
        chk("rx_q", q1, 11'b10100010110);

        // Priority: load beats arm and shift_en.
        step(1'b1, 1'b1, 1'b1, 1'b0, 11'h155);
        chk("prio_q_msb", q0, 11'h155);
        chk("prio_q_lsb", q1, 11'h155);
        chk("prio_count", count0, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom), '0);
        chk("mid_count", count0, 5);
        step(1'b1, 1'b0, 1'b0, 1'b0, N'($urandom));
        chk("restart_count", count0, 0);
        chk("restart_busy", busy0, 1);
        for (int i = 0; i < N - 1; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'($urandom), '0);
            chk("restart_no_done", done0, 0);
        end
        step(1'b0, 1'b0, 1'b1, 1'($urandom), '0);
        chk("restart_done", done0, 1);

        // Abort by reset at count 7, then free-running shifts while idle.
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom), '0);
        chk("abort_count", count0, 7);
        do_reset();
        chk("abort_busy", busy0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'($urandom), '0);
            chk("free_count", count0, 0);
            chk("free_done", done0, 0);
        end

        // Parity frames: odd ones, even ones, then odd followed by a clearing load.
        run_frame(11'b000_0010_0000);
`ifdef FRAME_SHIFT_PARITY_EN
        chk("par_odd", par0, 1);
`endif
        run_frame(11'b100_0010_0000);
`ifdef FRAME_SHIFT_PARITY_EN
        chk("par_even", par0, 0);
`endif
        run_frame(11'b111_0000_0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
`ifdef FRAME_SHIFT_PARITY_EN
        chk("par_load_clear", par0, 0);
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 199);
            if (r == 199) do_reset();
            else step(r < 6, (r >= 6) && (r < 12), 1'($urandom), 1'($urandom), N'($urandom));
        end

        idle();
        @(negedge clk);
        chk("sb_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
